// File: rtl/score_bcd_display.sv
// Game-score counter with a packed-BCD score, a high-score register and a
// multiplexed common-anode seven-segment driver.
// The score is kept in BCD so the display never needs divide/modulo.
// Ticks accumulate while run is high, and bonus strobes add one point.
// The sum saturates at all-nines.
// The high score is captured on the falling edge of run.

module score_bcd_display #(
  parameter int NUM_DIGITS    = 4,
  parameter int TICK_DIV      = 100000000,
  parameter int REFRESH_DIV   = 262144,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    bonus_valid,
  input  logic                    show_high,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    saturated
);

  localparam int W   = 4 * NUM_DIGITS;
  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [W-1:0]   ALL_NINES    = {NUM_DIGITS{4'h9}};
  localparam logic [TCW-1:0] TICK_LAST    = TCW'(TICK_DIV - 1);
  localparam logic [RCW-1:0] REFRESH_LAST = RCW'(REFRESH_DIV - 1);
  localparam logic [DIW-1:0] DIGIT_LAST   = DIW'(NUM_DIGITS - 1);

  // BCD add of a small increment (0..2) with ripple carry.
  // The top bit of the result flags overflow past all-nines.
  function automatic logic [W:0] bcd_add(input logic [W-1:0] val,
                                         input logic [1:0]   inc);
    logic [W-1:0] sum;
    logic [4:0]   dsum;
    logic [4:0]   dadj;
    logic [1:0]   carry;
    sum   = {W{1'b0}};
    carry = inc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dsum = {1'b0, val[4*i +: 4]} + {3'b000, carry};
      dadj = dsum - 5'd10;
      if (dsum > 5'd9) begin
        sum[4*i +: 4] = dadj[3:0];
        carry         = 2'd1;
      end else begin
        sum[4*i +: 4] = dsum[3:0];
        carry         = 2'd0;
      end
    end
    return {(carry != 2'd0), sum};
  endfunction

  // Active-low {a,b,c,d,e,f,g} pattern for one BCD digit; non-BCD is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0000100;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Game state
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic [W-1:0]   score_q, score_d;
  logic [W-1:0]   high_q, high_d;
  logic           saturated_q, saturated_d;
  logic           run_q;
  logic           tick_s;
  logic           end_game_s;
  logic [1:0]     inc_s;
  logic [W:0]     add_s;

  // Display state
  logic [RCW-1:0]        refresh_q, refresh_d;
  logic [DIW-1:0]        digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [W-1:0]          disp_s;
  logic [3:0]            digits_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_s;
  logic [3:0]            cur_nib_s;

  // Next-state for tick counter, score, saturation flag and high score.
  always_comb begin
    tick_s     = run && (tick_cnt_q == TICK_LAST);
    inc_s      = {1'b0, tick_s} + {1'b0, bonus_valid};
    add_s      = bcd_add(score_q, inc_s);
    end_game_s = run_q && !run;

    tick_cnt_d = tick_cnt_q;
    score_d    = score_q;
    high_d     = high_q;

    if (clear) begin
      tick_cnt_d = {TCW{1'b0}};
    end else if (run) begin
      tick_cnt_d = tick_s ? {TCW{1'b0}} : (tick_cnt_q + TCW'(1'b1));
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    if (clear) begin
      score_d = {W{1'b0}};
    end else if (add_s[W]) begin
      score_d = ALL_NINES;
    end else begin
      score_d = add_s[W-1:0];
    end

    // Score can only leave all-nines through clear, so the flag tracks it.
    saturated_d = (score_d == ALL_NINES);

    // Compare against the pre-update score so a same-cycle bonus or clear
    // does not affect the captured high score.
    if (end_game_s && (score_q > high_q)) begin
      high_d = score_q;
    end else begin
      high_d = high_q;
    end
  end

  // Game-state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= {TCW{1'b0}};
      score_q     <= {W{1'b0}};
      high_q      <= {W{1'b0}};
      saturated_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      score_q     <= score_d;
      high_q      <= high_d;
      saturated_q <= saturated_d;
      run_q       <= run;
    end
  end

  // Refresh counter and digit index; index 0 is the leftmost digit.
  always_comb begin
    refresh_d   = refresh_q;
    digit_idx_d = digit_idx_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d   = {RCW{1'b0}};
      digit_idx_d = (digit_idx_q == DIGIT_LAST) ? {DIW{1'b0}}
                                                : (digit_idx_q + DIW'(1'b1));
    end else begin
      refresh_d   = refresh_q + RCW'(1'b1);
      digit_idx_d = digit_idx_q;
    end
  end

  // Select the displayed digit, apply leading-zero blanking and decode.
  always_comb begin
    logic lead_zero;
    disp_s    = show_high ? high_q : score_q;
    lead_zero = 1'b1;
    blank_s   = {NUM_DIGITS{1'b0}};
    an_d      = {NUM_DIGITS{1'b1}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digits_s[k] = disp_s[4*(NUM_DIGITS-1-k) +: 4];
      lead_zero   = lead_zero && (digits_s[k] == 4'd0);
      blank_s[k]  = BLANK_LEADING && lead_zero && (k != NUM_DIGITS - 1);
      an_d[NUM_DIGITS-1-k] = (digit_idx_q != DIW'(k));
    end
    cur_nib_s = digits_s[digit_idx_q];
    seg_d     = blank_s[digit_idx_q] ? 7'b1111111 : seg_decode(cur_nib_s);
  end

  // Scan registers and registered anode/segment pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q   <= {RCW{1'b0}};
      digit_idx_q <= {DIW{1'b0}};
      an_q        <= {NUM_DIGITS{1'b1}};
      seg_q       <= 7'b1111111;
    end else begin
      refresh_q   <= refresh_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign saturated = saturated_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed self-checking bench for score_bcd_display.
// It uses a short tick period and a short refresh period so that scan, carry,
// saturation and high-score behaviour all fit in a short run.

module tb_score_bcd_display;

  logic        clk;
  logic        reset;
  logic        run;
  logic        clear;
  logic        bonus_valid;
  logic        show_high;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] score_bcd;
  logic [15:0] high_bcd;
  logic        saturated;

  int n_cmp;
  int n_err;
  int edge_n;

  score_bcd_display #(
    .NUM_DIGITS    (4),
    .TICK_DIV      (4),
    .REFRESH_DIV   (2),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .clear       (clear),
    .bonus_valid (bonus_valid),
    .show_high   (show_high),
    .an          (an),
    .seg         (seg),
    .score_bcd   (score_bcd),
    .high_bcd    (high_bcd),
    .saturated   (saturated)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; sample point is 1 ns after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  // Check eight scan edges against a per-digit segment table (digit 0 on top).
  // The anode lags the digit index by one edge.
  // The index advances every second edge counted from reset release.
  task automatic scan_check(input string tag, input logic [27:0] segs);
    int         idx;
    logic [3:0] one_hot;
    logic [6:0] seg_exp;
    for (int i = 0; i < 8; i++) begin
      step(1);
      idx     = ((edge_n - 1) / 2) % 4;
      one_hot = 4'b1000;
      seg_exp = segs[27 - 7*idx -: 7];
      check_val({tag, "_an"}, {28'd0, an}, {28'd0, ~(one_hot >> idx)});
      check_val({tag, "_seg"}, {25'd0, seg}, {25'd0, seg_exp});
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    edge_n      = 0;
    reset       = 1'b1;
    run         = 1'b0;
    clear       = 1'b0;
    bonus_valid = 1'b0;
    show_high   = 1'b0;

    // Reset state
    step(3);
    check_val("rst_score", {16'd0, score_bcd}, 32'h0000);
    check_val("rst_high",  {16'd0, high_bcd},  32'h0000);
    check_val("rst_sat",   {31'd0, saturated}, 32'd0);
    check_val("rst_an",    {28'd0, an},        32'hF);
    check_val("rst_seg",   {25'd0, seg},       32'h7F);
    reset  = 1'b0;
    edge_n = 0;

    // Ten ticks at TICK_DIV=4 over 40 running cycles
    run = 1'b1;
    step(1);
    check_val("first_an",  {28'd0, an},  {28'd0, 4'b0111});
    check_val("first_seg", {25'd0, seg}, {25'd0, 7'b1111111});
    step(2);
    check_val("tick_pre",  {16'd0, score_bcd}, 32'h0000);
    step(1);
    check_val("tick_1",    {16'd0, score_bcd}, 32'h0001);
    step(36);
    check_val("tick_10",   {16'd0, score_bcd}, 32'h0010);
    run = 1'b0;
    step(1);
    check_val("end1_high", {16'd0, high_bcd}, 32'h0010);

    // Carry across two digits: 0099 + tick + bonus
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("clr_score", {16'd0, score_bcd}, 32'h0000);
    check_val("clr_high",  {16'd0, high_bcd},  32'h0010);
    bonus_valid = 1'b1;
    step(99);
    bonus_valid = 1'b0;
    check_val("bonus_99",  {16'd0, score_bcd}, 32'h0099);
    run = 1'b1;
    step(3);
    check_val("hold_99",   {16'd0, score_bcd}, 32'h0099);
    bonus_valid = 1'b1;
    step(1);
    bonus_valid = 1'b0;
    check_val("carry_101", {16'd0, score_bcd}, 32'h0101);
    run = 1'b0;
    step(1);
    check_val("end2_high", {16'd0, high_bcd}, 32'h0101);

    // Single-tick carry 0019 -> 0020, then a lower game keeps high
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    bonus_valid = 1'b1;
    step(19);
    bonus_valid = 1'b0;
    run = 1'b1;
    step(3);
    check_val("hold_19",   {16'd0, score_bcd}, 32'h0019);
    step(1);
    check_val("carry_20",  {16'd0, score_bcd}, 32'h0020);
    run = 1'b0;
    step(1);
    check_val("end3_high", {16'd0, high_bcd}, 32'h0101);

    // Scan with leading-zero blanking, score 0007
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    bonus_valid = 1'b1;
    step(7);
    bonus_valid = 1'b0;
    check_val("score_7", {16'd0, score_bcd}, 32'h0007);
    scan_check("scan7", {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111});

    // High score 1205 shown while live score is 0; internal zero stays lit
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    bonus_valid = 1'b1;
    step(1205);
    bonus_valid = 1'b0;
    check_val("score_1205", {16'd0, score_bcd}, 32'h1205);
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(1);
    check_val("high_1205", {16'd0, high_bcd}, 32'h1205);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("clr_0", {16'd0, score_bcd}, 32'h0000);
    show_high = 1'b1;
    step(1);
    scan_check("scanhi", {7'b1001111, 7'b0010010, 7'b0000001, 7'b0100100});

    // Asynchronous reset mid-scan
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_an",    {28'd0, an},        32'hF);
    check_val("arst_seg",   {25'd0, seg},       32'h7F);
    check_val("arst_high",  {16'd0, high_bcd},  32'h0000);
    check_val("arst_score", {16'd0, score_bcd}, 32'h0000);
    show_high = 1'b0;
    step(2);
    reset  = 1'b0;
    edge_n = 0;

    // High-score capture: 0017, then 0042 with same-cycle bonus, then 0030
    bonus_valid = 1'b1;
    step(17);
    bonus_valid = 1'b0;
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(1);
    check_val("high_17", {16'd0, high_bcd}, 32'h0017);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    bonus_valid = 1'b1;
    step(42);
    bonus_valid = 1'b0;
    run = 1'b1;
    step(1);
    run         = 1'b0;
    bonus_valid = 1'b1;
    step(1);
    bonus_valid = 1'b0;
    check_val("high_42",    {16'd0, high_bcd},  32'h0042);
    check_val("score_43",   {16'd0, score_bcd}, 32'h0043);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("clr_keep42", {16'd0, high_bcd},  32'h0042);
    bonus_valid = 1'b1;
    step(30);
    bonus_valid = 1'b0;
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(1);
    check_val("high_stay42", {16'd0, high_bcd}, 32'h0042);

    // Saturation at 9999; clear together with end of game
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    bonus_valid = 1'b1;
    step(9998);
    bonus_valid = 1'b0;
    check_val("score_9998", {16'd0, score_bcd}, 32'h9998);
    check_val("sat_9998",   {31'd0, saturated}, 32'd0);
    run = 1'b1;
    step(3);
    bonus_valid = 1'b1;
    step(1);
    check_val("sat_score",  {16'd0, score_bcd}, 32'h9999);
    check_val("sat_flag",   {31'd0, saturated}, 32'd1);
    step(8);
    bonus_valid = 1'b0;
    check_val("sat_hold",   {16'd0, score_bcd}, 32'h9999);
    check_val("sat_flag2",  {31'd0, saturated}, 32'd1);
    run   = 1'b0;
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_val("sclr_score", {16'd0, score_bcd}, 32'h0000);
    check_val("sclr_sat",   {31'd0, saturated}, 32'd0);
    check_val("sclr_high",  {16'd0, high_bcd},  32'h9999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
